// File: rtl/brc_pkg.sv
// brc_pkg: shared encodings for the branch hazard controller.
// Holds the comparator operand select codes and the stall FSM state enum.
package brc_pkg;
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;
  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_e;
endpackage

// File: rtl/brc_fwd_sel.sv
// brc_fwd_sel: one branch operand's hazard match, forward select and required stall length.
// Ports: id_branch/src (operand), ex_*/mem_*/wb_* pipeline destinations,
//        fwd (operand select, unforced), need (stall cycles this operand requires).
module brc_fwd_sel import brc_pkg::*; #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int FWD_WB   = 1,
  parameter int CW       = 2
) (
  input  logic              id_branch,
  input  logic [REG_AW-1:0] src,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_reg_write,
  input  logic              mem_mem_read,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  output fwd_sel_e          fwd,
  output logic [CW-1:0]     need
);
  logic ex_m, mem_m, wb_m;
  logic [CW-1:0] n_ex, n_mem, n_wb, n_x;
  always_comb begin
    ex_m  = id_branch && ex_reg_write && ex_rd == src && src != '0;
    mem_m = id_branch && mem_reg_write && mem_rd == src && src != '0;
    wb_m  = id_branch && wb_reg_write && wb_rd == src && src != '0;
    n_ex  = !ex_m ? '0 : ex_mem_read ? CW'(1 + LOAD_LAT) : CW'(1);
    n_mem = mem_m && mem_mem_read ? CW'(LOAD_LAT) : '0;
    n_wb  = FWD_WB == 0 && wb_m ? CW'(1) : '0;
    // a slow load in MEM can outlast an ALU result in EX, so take the true maximum
    n_x   = n_ex > n_mem ? n_ex : n_mem;
    need  = n_x > n_wb ? n_x : n_wb;
    fwd   = mem_m && !mem_mem_read ? FWD_MEM :
            wb_m && FWD_WB != 0    ? brc_pkg::FWD_WB : FWD_RF;
  end
endmodule

// File: rtl/brc_hazard_ctrl.sv
// brc_hazard_ctrl: ID-stage branch comparator forwarding and stall control.
// Ports: clk, rst (async, active-high); id_branch, id_rs, id_rt; EX/MEM/WB destination
//        info; fwd_a/fwd_b operand selects; pc_write, ifid_write, id_flush; stall_busy.
// Optional: define BRC_HAZARD_STATS_EN to add the 32-bit saturating stall_cycles output.
module brc_hazard_ctrl import brc_pkg::*; #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int FWD_WB   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_branch,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_reg_write,
  input  logic              mem_mem_read,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              id_flush,
  output logic              stall_busy
`ifdef BRC_HAZARD_STATS_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);
  localparam int CW = $clog2(LOAD_LAT + 2);
  state_e state;
  logic [CW-1:0] cnt, need_a, need_b, n;
  fwd_sel_e sel_a, sel_b;
  logic stall;
  brc_fwd_sel #(.REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT), .FWD_WB(FWD_WB), .CW(CW)) u_rs (
    .id_branch(id_branch), .src(id_rs),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_rd(mem_rd),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .fwd(sel_a), .need(need_a)
  );
  brc_fwd_sel #(.REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT), .FWD_WB(FWD_WB), .CW(CW)) u_rt (
    .id_branch(id_branch), .src(id_rt),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_rd(mem_rd),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .fwd(sel_b), .need(need_b)
  );
  always_comb begin
    n          = need_a > need_b ? need_a : need_b;
    // rst gates the combinational detect so reset forces "advance" without a clock edge
    stall      = !rst && (state == STALL || n != '0);
    pc_write   = !stall;
    ifid_write = !stall;
    id_flush   = stall;
    stall_busy = state == STALL;
    fwd_a      = stall ? FWD_RF : sel_a;
    fwd_b      = stall ? FWD_RF : sel_b;
  end
  // the first stall cycle is spent in IDLE, so STALL holds the remaining N-1 cycles
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (state == STALL) begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) state <= IDLE;
    end else if (n != '0) begin
      cnt   <= n - CW'(1);
      state <= n > CW'(1) ? STALL : IDLE;
    end
`ifdef BRC_HAZARD_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) stall_cycles <= '0;
    else if (id_flush && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
`endif
endmodule

// File: doc/brc_hazard_ctrl.md
BRC_HAZARD_CTRL -- requirements
Module: brc_hazard_ctrl

Interface
REQ-001: Parameter REG_AW, default 5, register-address width.
REQ-002: Parameter LOAD_LAT, default 1 (range 1..7), data-memory load latency in cycles.
REQ-003: Parameter FWD_WB, default 1, enables the MEM/WB forwarding path (0 = EX/MEM only).
REQ-004: clk  in  1  single clock; all state on rising edge.
REQ-005: rst  in  1  asynchronous, active-high reset.
REQ-006: id_branch  in  1  branch in ID needs rs/rt compared this cycle.
REQ-007: id_rs, id_rt  in  REG_AW  branch source registers.
REQ-008: ex_reg_write, ex_mem_read  in  1  ID/EX control; ex_rd  in  REG_AW  EX destination.
REQ-009: mem_reg_write, mem_mem_read  in  1  EX/MEM control; mem_rd  in  REG_AW  MEM destination.
REQ-010: wb_reg_write  in  1, wb_rd  in  REG_AW  MEM/WB writeback.
REQ-011: fwd_a, fwd_b  out  2  comparator operand select: 00 regfile, 01 EX/MEM, 10 MEM/WB.
REQ-012: pc_write, ifid_write  out  1  high = advance; id_flush  out  1  high = bubble into ID/EX.
REQ-013: stall_busy  out  1  high while stall counter is non-zero.

Function
REQ-014: Hazard matching SHALL ignore register 0; a source "matches" a stage only when that stage's write enable is high and its rd equals the source and is non-zero.
REQ-015: Forwarding SHALL be combinational: per operand, an EX/MEM match with mem_mem_read=0 selects 01; else a MEM/WB match with FWD_WB=1 selects 10; else 00.
REQ-016: With id_branch=0, fwd_a/fwd_b SHALL be 00 and no new stall SHALL be detected.
REQ-017: Required stall length N: EX match, ex_mem_read=0 -> 1; EX match, ex_mem_read=1 -> 1+LOAD_LAT; MEM match, mem_mem_read=1 -> LOAD_LAT; FWD_WB=0 and WB match -> 1; otherwise 0. Multiple matches take the maximum.
REQ-018: Two-state FSM IDLE/STALL with counter cnt (width ceil(log2(LOAD_LAT+2))).
REQ-019: IDLE, N>0: stall outputs asserted that cycle; next edge cnt<=N-1, go to STALL if N>1, else stay IDLE.
REQ-020: STALL: stall outputs asserted; cnt decrements each edge; at cnt==1 the next state is IDLE with cnt 0.
REQ-021: STALL SHALL ignore new detections (ID is frozen), and no cycle SHALL be added or dropped when id_branch deasserts mid-stall.
REQ-022: Stall outputs: pc_write=0, ifid_write=0, id_flush=1; otherwise 1,1,0.
REQ-023: stall_busy SHALL equal (state==STALL).
REQ-024: Forward selects SHALL be forced to 00 while stall outputs are asserted.

Reset
REQ-025: While rst is high: state IDLE, cnt 0, stall_busy 0, pc_write 1, ifid_write 1, id_flush 0, taking effect without a clock edge.
REQ-026: Reset mid-STALL SHALL abort the stall immediately; the first edge after release behaves as from IDLE.

Configuration
REQ-027: With macro BRC_HAZARD_STATS_EN defined, output stall_cycles (32-bit) SHALL count cycles with id_flush=1, saturate at 0xFFFFFFFF, and clear on rst.
REQ-028: Without BRC_HAZARD_STATS_EN, the port and the counter SHALL be absent and all other behaviour identical.

Structure
REQ-029: Package brc_pkg SHALL hold the fwd_sel encodings (FWD_RF=00, FWD_MEM=01, FWD_WB=10) and the state enum (IDLE, STALL).
REQ-030: Sub-module brc_fwd_sel SHALL implement one operand's match/priority logic and be instantiated twice, once for rs and once for rt.

Verification
REQ-031: LOAD_LAT=2; branch rs=5, EX load rd=5 -> stall exactly 3 cycles (id_flush 1,1,1), stall_busy high on cycles 2-3.
REQ-032: Branch rs=3,rt=4; MEM ALU rd=3, WB rd=4 -> fwd_a=01, fwd_b=10, no stall; same case with FWD_WB=0 -> fwd_b=00 and a 1-cycle stall.
REQ-033: Branch rs=0; EX writes rd=0 -> no stall, fwd_a=00.
REQ-034: Assert rst during cycle 2 of a 3-cycle stall -> outputs 1,1,0 immediately, stall_busy 0, no residual stall after release.
REQ-035: EX ALU rd=7 and MEM load rd=7 (LOAD_LAT=1) -> N=max(1,1)=1, single stall cycle; then with STATS_EN, stall_cycles increments by 1.
